// File: rtl/alu_station.sv
// ALU reservation station: age-ordered collapsing queue that captures AL issues,
// snoops two CDBs for operand wakeup and offers the oldest ready entry to the ALU.
module alu_station #(
    parameter int         DEPTH   = 8,
    parameter int         XLEN    = 32,
    parameter int         TAG_W   = 6,
    parameter int         OP_W    = 8,
    parameter logic [2:0] AL_TYPE = 3'd0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [1:0]                 in_valid,
    input  logic [1:0][2:0]            in_type,
    input  logic [1:0][OP_W-1:0]       in_op,
    input  logic [1:0][XLEN-1:0]       in_address,
    input  logic [1:0][XLEN-1:0]       in_imm,
    input  logic [1:0][TAG_W-1:0]      in_src1_tag,
    input  logic [1:0][TAG_W-1:0]      in_src2_tag,
    input  logic [1:0][TAG_W-1:0]      in_dst_tag,
    input  logic [1:0]                 in_src1_rdy,
    input  logic [1:0]                 in_src2_rdy,
    input  logic [1:0][XLEN-1:0]       in_src1_val,
    input  logic [1:0][XLEN-1:0]       in_src2_val,
    input  logic [1:0]                 cdb_valid,
    input  logic [1:0][TAG_W-1:0]      cdb_tag,
    input  logic [1:0][XLEN-1:0]       cdb_value,
    output logic                       full,
    output logic                       ex_valid,
    input  logic                       ex_ready,
    output logic [OP_W-1:0]            ex_op,
    output logic [XLEN-1:0]            ex_a,
    output logic [XLEN-1:0]            ex_b,
    output logic [XLEN-1:0]            ex_imm,
    output logic [XLEN-1:0]            ex_address,
    output logic [TAG_W-1:0]           ex_dst_tag
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [XLEN-1:0]   address;
        logic [XLEN-1:0]   imm;
        logic [TAG_W-1:0]  dst_tag;
        logic [TAG_W-1:0]  s1_tag;
        logic              s1_rdy;
        logic [XLEN-1:0]   s1_val;
        logic [TAG_W-1:0]  s2_tag;
        logic              s2_rdy;
        logic [XLEN-1:0]   s2_val;
    } entry_t;

    entry_t         q     [DEPTH];
    entry_t         woke  [DEPTH];
    entry_t         q_nxt [DEPTH];
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic [IW-1:0]  sel_idx;
    logic           dispatch;

    // CDB 0 is checked first so it wins when both ports carry the same tag.
    function automatic logic [XLEN:0] wake(input logic [TAG_W-1:0] tag,
                                           input logic             rdy,
                                           input logic [XLEN-1:0]  val);
        if (rdy)
            return {1'b1, val};
        if (cdb_valid[0] && cdb_tag[0] == tag)
            return {1'b1, cdb_value[0]};
        if (cdb_valid[1] && cdb_tag[1] == tag)
            return {1'b1, cdb_value[1]};
        return {1'b0, val};
    endfunction

    always_comb begin
        ex_valid = 1'b0;
        sel_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (q[i].valid && q[i].s1_rdy && q[i].s2_rdy) begin
                ex_valid = 1'b1;
                sel_idx  = IW'(i);
            end
        end
    end

    always_comb begin
        ex_op      = '0;
        ex_a       = '0;
        ex_b       = '0;
        ex_imm     = '0;
        ex_address = '0;
        ex_dst_tag = '0;
        if (ex_valid) begin
            ex_op      = q[sel_idx].op;
            ex_a       = q[sel_idx].s1_val;
            ex_b       = q[sel_idx].s2_val;
            ex_imm     = q[sel_idx].imm;
            ex_address = q[sel_idx].address;
            ex_dst_tag = q[sel_idx].dst_tag;
        end
    end

    assign full     = (int'(count) > DEPTH - 2);
    assign dispatch = ex_valid && ex_ready;

    always_comb begin
        int     pos;
        entry_t inc;
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = q[i];
            {woke[i].s1_rdy, woke[i].s1_val} = wake(q[i].s1_tag, q[i].s1_rdy, q[i].s1_val);
            {woke[i].s2_rdy, woke[i].s2_val} = wake(q[i].s2_tag, q[i].s2_rdy, q[i].s2_val);
        end
        // Entries at and above the dispatched slot collapse down by one.
        for (int i = 0; i < DEPTH; i++) begin
            q_nxt[i] = woke[i];
            if (dispatch && i >= int'(sel_idx)) begin
                if (i == DEPTH - 1)
                    q_nxt[i] = '0;
                else
                    q_nxt[i] = woke[(i < DEPTH - 1) ? i + 1 : i];
            end
        end
        pos = int'(count) - (dispatch ? 1 : 0);
        for (int k = 0; k < 2; k++) begin
            inc         = '0;
            inc.valid   = 1'b1;
            inc.op      = in_op[k];
            inc.address = in_address[k];
            inc.imm     = in_imm[k];
            inc.dst_tag = in_dst_tag[k];
            inc.s1_tag  = in_src1_tag[k];
            inc.s2_tag  = in_src2_tag[k];
            {inc.s1_rdy, inc.s1_val} = wake(in_src1_tag[k], in_src1_rdy[k], in_src1_val[k]);
            {inc.s2_rdy, inc.s2_val} = wake(in_src2_tag[k], in_src2_rdy[k], in_src2_val[k]);
            if (in_valid[k] && in_type[k] == AL_TYPE && pos < DEPTH) begin
                q_nxt[pos] = inc;
                pos = pos + 1;
            end
        end
        count_nxt = CW'(pos);
    end

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            for (int i = 0; i < DEPTH; i++)
                q[i] <= '0;
            count <= '0;
        end else begin
            q     <= q_nxt;
            count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_alu_station.sv
// Self-checking bench for alu_station: queue-based behavioural model, per-cycle
// compare on the falling edge, directed scenarios followed by random traffic.
module tb_alu_station;

    localparam int         DEPTH = 8;
    localparam logic [2:0] AL    = 3'd0;
    localparam logic [2:0] BR    = 3'd2;

    logic              clock, reset, flush, ex_ready;
    logic [1:0]        in_valid, in_src1_rdy, in_src2_rdy, cdb_valid;
    logic [1:0][2:0]   in_type;
    logic [1:0][7:0]   in_op;
    logic [1:0][31:0]  in_address, in_imm, in_src1_val, in_src2_val, cdb_value;
    logic [1:0][5:0]   in_src1_tag, in_src2_tag, in_dst_tag, cdb_tag;
    logic              full, ex_valid;
    logic [7:0]        ex_op;
    logic [31:0]       ex_a, ex_b, ex_imm, ex_address;
    logic [5:0]        ex_dst_tag;

    int checks = 0;
    int errors = 0;
    bit armed  = 0;

    alu_station #(.DEPTH(DEPTH), .XLEN(32), .TAG_W(6), .OP_W(8), .AL_TYPE(AL)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_type(in_type), .in_op(in_op),
        .in_address(in_address), .in_imm(in_imm),
        .in_src1_tag(in_src1_tag), .in_src2_tag(in_src2_tag), .in_dst_tag(in_dst_tag),
        .in_src1_rdy(in_src1_rdy), .in_src2_rdy(in_src2_rdy),
        .in_src1_val(in_src1_val), .in_src2_val(in_src2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .full(full), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_address(ex_address), .ex_dst_tag(ex_dst_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr, imm, v1, v2;
        logic [5:0]  dst, t1, t2;
        bit          r1, r2;
    } ment_t;

    ment_t mq[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int first_ready();
        foreach (mq[i])
            if (mq[i].r1 && mq[i].r2)
                return i;
        return -1;
    endfunction

    function automatic ment_t wake_ent(ment_t e);
        for (int j = 0; j < 2; j++) begin
            if (!e.r1 && cdb_valid[j] && cdb_tag[j] == e.t1) begin
                e.r1 = 1; e.v1 = cdb_value[j];
            end
            if (!e.r2 && cdb_valid[j] && cdb_tag[j] == e.t2) begin
                e.r2 = 1; e.v2 = cdb_value[j];
            end
        end
        return e;
    endfunction

    always @(posedge clock) begin
        if (!reset || flush) begin
            mq.delete();
            if (!reset) armed = 1;
        end else begin
            int sel;
            sel = first_ready();
            foreach (mq[i]) mq[i] = wake_ent(mq[i]);
            if (sel >= 0 && ex_ready) mq.delete(sel);
            for (int k = 0; k < 2; k++) begin
                if (in_valid[k] && in_type[k] == AL) begin
                    ment_t e;
                    e.op = in_op[k]; e.addr = in_address[k]; e.imm = in_imm[k];
                    e.dst = in_dst_tag[k];
                    e.t1 = in_src1_tag[k]; e.r1 = in_src1_rdy[k]; e.v1 = in_src1_val[k];
                    e.t2 = in_src2_tag[k]; e.r2 = in_src2_rdy[k]; e.v2 = in_src2_val[k];
                    e = wake_ent(e);
                    if (mq.size() < DEPTH) mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            int sel;
            sel = first_ready();
            chk("ex_valid", ex_valid, sel >= 0);
            chk("full", full, mq.size() > DEPTH - 2);
            chk("count", dut.count, mq.size());
            if (sel >= 0) begin
                chk("ex_op", ex_op, mq[sel].op);
                chk("ex_a", ex_a, mq[sel].v1);
                chk("ex_b", ex_b, mq[sel].v2);
                chk("ex_imm", ex_imm, mq[sel].imm);
                chk("ex_address", ex_address, mq[sel].addr);
                chk("ex_dst_tag", ex_dst_tag, mq[sel].dst);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        in_valid = '0; cdb_valid = '0; flush = 0; ex_ready = 0;
    endtask

    task automatic set_slot(input int k, input logic [2:0] ty, input logic [5:0] dst,
                            input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                            input logic [5:0] t2, input logic r2, input logic [31:0] v2);
        in_valid[k] = 1'b1;     in_type[k] = ty;
        in_op[k] = 8'(dst) + 8'h40;
        in_address[k] = 32'h1000 + 32'(dst);
        in_imm[k] = 32'(dst) * 3;
        in_dst_tag[k] = dst;
        in_src1_tag[k] = t1; in_src1_rdy[k] = r1; in_src1_val[k] = v1;
        in_src2_tag[k] = t2; in_src2_rdy[k] = r2; in_src2_val[k] = v2;
    endtask

    task automatic set_cdb(input int j, input logic [5:0] tag, input logic [31:0] val);
        cdb_valid[j] = 1'b1; cdb_tag[j] = tag; cdb_value[j] = val;
    endtask

    initial begin
        reset = 0; flush = 0; ex_ready = 0;
        in_valid = '0; in_type = '0; in_op = '0; in_address = '0; in_imm = '0;
        in_src1_tag = '0; in_src2_tag = '0; in_dst_tag = '0;
        in_src1_rdy = '0; in_src2_rdy = '0; in_src1_val = '0; in_src2_val = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0;

        // reset held with active inputs
        set_slot(0, AL, 6'd1, 6'd0, 1, 32'd9, 6'd0, 1, 32'd9);
        ex_ready = 1;
        tick(); tick();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_count", dut.count, 0);
        chk("rst_ex_a", ex_a, 0);
        reset = 1; clear_in();
        set_slot(0, AL, 6'd1, 6'd0, 1, 32'd5, 6'd0, 1, 32'd7);
        tick(); clear_in();
        chk("first_valid", ex_valid, 1);
        chk("first_a", ex_a, 5);
        chk("first_b", ex_b, 7);
        ex_ready = 1; tick(); clear_in();

        // non-AL slot 0 is skipped
        set_slot(0, BR, 6'd2, 6'd0, 1, 32'd1, 6'd0, 1, 32'd1);
        set_slot(1, AL, 6'd3, 6'd0, 1, 32'd2, 6'd0, 1, 32'd2);
        tick(); clear_in();
        chk("br_skip_dst", ex_dst_tag, 3);
        chk("br_skip_count", dut.count, 1);
        ex_ready = 1; tick(); clear_in();
        set_slot(0, AL, 6'd4, 6'd30, 0, 32'd0, 6'd31, 0, 32'd0);
        set_slot(1, AL, 6'd5, 6'd32, 0, 32'd0, 6'd33, 0, 32'd0);
        ex_ready = 1; tick(); in_valid = '0; tick(); clear_in();
        chk("unready_no_offer", ex_valid, 0);
        flush = 1; tick(); clear_in();

        // CDB wakeup, then dual-CDB priority
        set_slot(0, AL, 6'd6, 6'd9, 0, 32'd0, 6'd0, 1, 32'h77);
        tick(); clear_in();
        set_cdb(1, 6'd9, 32'h1234);
        tick(); clear_in();
        chk("cdb1_wake_valid", ex_valid, 1);
        chk("cdb1_wake_a", ex_a, 32'h1234);
        ex_ready = 1; tick(); clear_in();
        set_slot(0, AL, 6'd7, 6'd9, 0, 32'd0, 6'd0, 1, 32'h77);
        tick(); clear_in();
        set_cdb(0, 6'd9, 32'd1); set_cdb(1, 6'd9, 32'd2);
        tick(); clear_in();
        chk("cdb0_wins", ex_a, 1);
        ex_ready = 1; tick(); clear_in();

        // oldest-ready ordering: C, A, B
        set_slot(0, AL, 6'd10, 6'd40, 0, 32'd0, 6'd0, 1, 32'd1);
        set_slot(1, AL, 6'd11, 6'd41, 0, 32'd0, 6'd0, 1, 32'd1);
        tick(); clear_in();
        set_slot(0, AL, 6'd12, 6'd42, 0, 32'd0, 6'd0, 1, 32'd1);
        tick(); clear_in();
        set_cdb(0, 6'd42, 32'hC);
        tick(); clear_in();
        for (int c = 0; c < 3; c++) begin
            chk("hold_dst", ex_dst_tag, 12);
            chk("hold_a", ex_a, 32'hC);
            tick();
        end
        set_cdb(0, 6'd40, 32'hA); ex_ready = 1;
        tick(); clear_in();
        chk("order_second", ex_dst_tag, 10);
        set_cdb(1, 6'd41, 32'hB); ex_ready = 1;
        tick(); clear_in();
        chk("order_third", ex_dst_tag, 11);
        ex_ready = 1; tick(); clear_in();
        chk("order_drained", ex_valid, 0);

        // fullness threshold and overflow protection
        for (int c = 0; c < 3; c++) begin
            set_slot(0, AL, 6'(20 + 2 * c), 6'(50 + 2 * c), 0, 32'd0, 6'd0, 1, 32'd0);
            set_slot(1, AL, 6'(21 + 2 * c), 6'(51 + 2 * c), 0, 32'd0, 6'd0, 1, 32'd0);
            tick(); clear_in();
        end
        chk("count6_full", full, 0);
        set_slot(0, AL, 6'd60, 6'd0, 1, 32'd3, 6'd0, 1, 32'd4);
        tick(); clear_in();
        chk("count7_full", full, 1);
        ex_ready = 1; tick(); clear_in();
        chk("after_dispatch_full", full, 0);
        set_slot(0, AL, 6'd26, 6'd56, 0, 32'd0, 6'd0, 1, 32'd0);
        set_slot(1, AL, 6'd27, 6'd57, 0, 32'd0, 6'd0, 1, 32'd0);
        tick(); clear_in();
        chk("count8_full", full, 1);
        set_slot(0, AL, 6'd61, 6'd0, 1, 32'd1, 6'd0, 1, 32'd1);
        set_slot(1, AL, 6'd62, 6'd0, 1, 32'd1, 6'd0, 1, 32'd1);
        tick(); clear_in();
        chk("overflow_count", dut.count, 8);
        chk("overflow_no_offer", ex_valid, 0);
        flush = 1; tick(); clear_in();

        // flush mid-operation, then flush together with reset
        for (int c = 0; c < 2; c++) begin
            set_slot(0, AL, 6'(30 + 2 * c), 6'(50 + 2 * c), 0, 32'd0, 6'd0, 1, 32'd0);
            set_slot(1, AL, 6'(31 + 2 * c), 6'(51 + 2 * c), 0, 32'd0, 6'd0, 1, 32'd0);
            tick(); clear_in();
        end
        set_slot(0, AL, 6'd34, 6'd0, 1, 32'd8, 6'd0, 1, 32'd8);
        tick(); clear_in();
        chk("pre_flush_count", dut.count, 5);
        set_cdb(0, 6'd50, 32'd5); ex_ready = 1; flush = 1;
        set_slot(0, AL, 6'd35, 6'd0, 1, 32'd8, 6'd0, 1, 32'd8);
        tick(); clear_in();
        chk("flush_count", dut.count, 0);
        chk("flush_ex_valid", ex_valid, 0);
        chk("flush_full", full, 0);
        set_slot(0, AL, 6'd36, 6'd0, 1, 32'd8, 6'd0, 1, 32'd8);
        tick(); clear_in();
        reset = 0; flush = 1;
        set_slot(0, AL, 6'd37, 6'd0, 1, 32'd8, 6'd0, 1, 32'd8);
        tick(); clear_in(); reset = 1;
        chk("rst_flush_valid", ex_valid, 0);
        chk("rst_flush_count", dut.count, 0);
        chk("rst_flush_a", ex_a, 0);

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 2; k++) begin
                in_valid[k]    = 1'($urandom_range(0, 1)) && (!full || $urandom_range(0, 15) == 0);
                in_type[k]     = ($urandom_range(0, 3) != 0) ? AL : 3'($urandom_range(1, 7));
                in_op[k]       = 8'($urandom);
                in_address[k]  = $urandom;
                in_imm[k]      = $urandom;
                in_dst_tag[k]  = 6'($urandom);
                in_src1_tag[k] = 6'($urandom_range(0, 7));
                in_src2_tag[k] = 6'($urandom_range(0, 7));
                in_src1_rdy[k] = 1'($urandom_range(0, 1));
                in_src2_rdy[k] = 1'($urandom_range(0, 1));
                in_src1_val[k] = $urandom;
                in_src2_val[k] = $urandom;
                cdb_valid[k]   = 1'($urandom_range(0, 1));
                cdb_tag[k]     = 6'($urandom_range(0, 7));
                cdb_value[k]   = $urandom;
            end
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 99) == 0);
            reset    = ($urandom_range(0, 499) != 0);
            tick();
        end
        clear_in(); reset = 1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_station.md
# alu_station

Reservation station for the ALU execution unit, sitting directly downstream of the issuer. It captures up to two issued instructions per cycle whose type is AL and holds them in age order. It snoops two common-data-bus (CDB) result ports to wake pending operands and dispatches the oldest fully-ready entry to the ALU over a valid/ready handshake. It drives the ALU fullness bit that the issuer uses to halt issue.

## Interface
Parameters:
- DEPTH, 8, number of entries (≥ 4)
- XLEN, 32, data width
- TAG_W, 6, renamed-register/ROB tag width
- OP_W, 8, instr_name encoding width

Ports:
- clock  in  1  sole clock, all state on posedge
- reset  in  1  synchronous, active-low (0 = reset)
- flush  in  1  mispredict flush; clears all entries
- in_valid[2]  in  1  issue slot k carries an instruction (slot 0 older)
- in_type[2]  in  3  instr_type; only AL is accepted
- in_op[2]  in  OP_W  instr_name
- in_address[2], in_imm[2]  in  XLEN  PC and immediate
- in_src1_tag[2], in_src2_tag[2], in_dst_tag[2]  in  TAG_W  renamed tags
- in_src1_rdy[2], in_src2_rdy[2]  in  1  operand value already present
- in_src1_val[2], in_src2_val[2]  in  XLEN  operand values (valid when rdy)
- cdb_valid[2], cdb_tag[2], cdb_value[2]  in  1/TAG_W/XLEN  result broadcasts
- full  out  1  to fullness.alu; 1 when free entries < 2
- ex_valid  out  1  dispatch offer
- ex_ready  in  1  ALU accepts this cycle
- ex_op, ex_a, ex_b, ex_imm, ex_address, ex_dst_tag  out  widths as above  dispatched payload

## Operation
- Storage: collapsing queue, entry 0 oldest. Per entry: valid, op, address, imm, dst_tag, and per source: tag, rdy, value.
- count = number of valid entries, 0..DEPTH.
- Enqueue: slots with in_valid=1 and in_type=AL are written at the first free positions above the surviving entries, slot 0 below slot 1. A non-AL slot is ignored, and slot 1 AL then takes the position slot 0 would have.
- Wakeup: for each stored source with rdy=0, if cdb_valid[j] and cdb_tag[j]==tag, value←cdb_value[j] and rdy←1. If both CDBs match, CDB 0 wins.
- Enqueue bypass: an incoming source with rdy=0 also compares against the CDBs in its enqueue cycle and is stored ready if matched.
- Select: the lowest-index entry with valid & src1.rdy & src2.rdy drives ex_*. ex_valid=1 if such an entry exists.
  - ex_a = src1.value, ex_b = src2.value.
  - ex_* are combinational from registered state; CDB results are not forwarded to ex_* in the same cycle.
- Dispatch: on ex_valid & ex_ready, the selected entry is removed at the edge and the entries above it shift down by one in the same edge. Enqueue lands above the post-shift top.
- full = (count > DEPTH-2), combinational from the registered count only. It gives no credit for a same-cycle dispatch.
- Overflow: if accepted instructions would exceed DEPTH, the excess youngest slot is dropped and stored entries stay intact. A correct issuer never causes this.
- Priority: reset (0) > flush > dispatch/enqueue/wakeup. Flush clears all valid bits and discards same-cycle inputs.

## Timing
- Reset values: all entries invalid, count=0, full=0, ex_valid=0, all ex_* data outputs 0.
- Enqueue at edge N → entry visible from cycle N+1. Fully ready on enqueue → ex_valid in cycle N+1 (1-cycle latency).
- CDB match at edge N → entry selectable in cycle N+1.
- Dispatch, enqueue of 2, and dual CDB wakeup may all occur on one edge. The shifted entries keep their wakeup updates.
- ex_valid held with ex_ready=0: the payload stays stable unless an older entry becomes ready. Entries are not locked, so oldest-ready always wins.
- Reset or flush mid-operation: on the next cycle count=0 and ex_valid=0, and in-flight inputs of that cycle are lost.
- DEPTH=8: full is 1 at count 7 and 8, 0 at count ≤ 6.

## Test plan
- Reset low for 2 cycles with inputs active → count=0, ex_valid=0, full=0. After release, enqueue one AL with both srcs ready (a=5, b=7) → next cycle ex_valid=1, ex_a=5, ex_b=7.
- Slot 0 BR, slot 1 AL (dst 3) → only dst 3 stored at entry 0. Two ALs with operands unready, ex_ready=1 → ex_valid stays 0.
- Entry with src1_tag=9 unready: cdb_valid[1]=1, tag 9, value 0x1234 → next cycle ex_a=0x1234, ex_valid=1. Repeat with both CDBs matching tag 9 (values 1 and 2) → ex_a=1.
- Enqueue 3 ALs (ids A,B,C), make C ready first, then A, then B → dispatch order C, A, B. Hold ex_ready=0 for 3 cycles while C is offered → payload unchanged.
- Fill to count 6 → full=0. Enqueue 1 more → full=1. Dispatch 1 → count 6 and full=0 on the next cycle. With count 8, in_valid on both slots → no entry is overwritten.
- count 5 with a CDB hit and dispatch pending, assert flush → next cycle count=0, ex_valid=0, full=0. flush together with reset=0 → reset values.
